mcss_stream_loader: RTL
=======================

# mcss_stream_loader

Upstream feeder for the MCSS reduction tree. Accepts a serial valid/ready stream of signed two's-complement words and packs them into a ROWS-wide parallel frame driving the MCSS array's `input_vals`. It holds the frame stable for the tree's pipeline latency, then captures the returned `mcss_val` and presents it on a valid/ready result port. One frame is in flight at a time; no overlap between frames.

## Interface
- DATA_WIDTH, 32, element and result width (signed two's complement)
- ROWS, 256, frame length; power of 2, ≥2; must equal the MCSS instance's ROWS
- LATENCY (localparam), $clog2(ROWS), MCSS tree depth in register stages

- clk  in  1  clock
- rst_l  in  1  reset; asynchronous, active-low
- in_valid  in  1  input element valid
- in_ready  out  1  loader accepts an element this cycle
- in_data  in  DATA_WIDTH  input element
- in_last  in  1  final element of the frame; remaining slots are zero-padded
- rows_out  out  ROWS×DATA_WIDTH  packed frame to MCSS `input_vals`; element k at index k
- mcss_in  in  DATA_WIDTH  MCSS `mcss_val`
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  DATA_WIDTH  captured MCSS value
- frame_len  out  $clog2(ROWS)+1  count of elements accepted into the current or last frame

## Operation
- States: FILL, WAIT, DONE.
- FILL: `in_ready` = 1. On `in_valid && in_ready`, write `in_data` to `rows_out[idx]`, then `idx++` and `frame_len++`.
  - Go to WAIT when the accepted element has `in_last`=1 or `idx == ROWS-1`.
  - At `idx == ROWS-1`, `in_last` is ignored; the frame closes either way.
- WAIT: `in_ready` = 0; `in_valid` is ignored and no data is written.
  - `wcnt` counts from 0 to LATENCY.
  - When `wcnt == LATENCY`: `res_data <= mcss_in`, go to DONE.
- DONE: `res_valid` = 1; `res_data` and `rows_out` are held stable.
  - On `res_ready`: clear all of `rows_out` to 0, set `idx` = 0, `frame_len` = 0, `wcnt` = 0, go to FILL.
- Zero padding is correct because MCSS of the empty subarray is 0, so trailing zeros never change the result.
- `rows_out` changes only on accepted writes in FILL and on the DONE→FILL clear.
- No arithmetic in this block. `frame_len` saturates at ROWS by construction.
- Reset values: state = FILL, `rows_out` = 0, `res_data` = 0, `res_valid` = 0, `frame_len` = 0, `idx` = 0, `wcnt` = 0. `in_ready` = 1 as soon as reset is released.
- Reset mid-operation (any state): all of the above return to reset values immediately. A partial frame is discarded and no result is emitted. MCSS shares `rst_l`, so its pipeline is also flushed.

## Timing
- `in_ready` and `res_valid` are decoded combinationally from the state register only, never from `in_valid` or `res_ready`.
- Let the last element be accepted at edge E0.
  - E0: `rows_out` is final and the state enters WAIT.
  - Edges E1 to E_LATENCY: `mcss_val` propagates through the tree.
  - E_(LATENCY+1): capture.
  - `res_valid` rises LATENCY+1 cycles after E0 (3 cycles for ROWS=4).
- DONE→FILL takes 1 edge. `in_ready` is high in the cycle after the `res_valid && res_ready` handshake.
- Minimum frame period = N accepts + LATENCY+1 + 1 cycles, where N is the number of elements in the frame.
- Back-to-back accepts occur every cycle in FILL.

## Structure
- Package `mcss_pkg`:
  - `typedef enum logic [1:0] {FILL, WAIT, DONE} mcss_ld_state_t`
  - function `mcss_latency(rows)` returning `$clog2(rows)`, shared with MCSS-side users
- Single module with no sub-modules. The MCSS instance sits beside it at the top level, not inside.
- Benches instantiate the loader plus MCSS with DATA_WIDTH=8, ROWS=4 (LATENCY=2).

## Test plan
- Stream 2,-3,4,-1 (`in_last` on 4th) → `res_data`=4, `frame_len`=4, `res_valid` rises 3 cycles after the 4th accept.
- Stream -1,-2,-3,-4 → `res_data`=0.
- Stream 5, -1(`in_last`) → `rows_out`={0,0,-1,5}, `res_data`=5, `frame_len`=2.
- Hold `res_ready`=0 for 10 cycles in DONE while driving `in_valid`=1 → `in_ready`=0 throughout, `res_data` and `rows_out` unchanged. After `res_ready`=1: `rows_out`=0 and `in_ready`=1 next cycle.
- Pulse `rst_l` low during WAIT (`wcnt`=1) → all outputs at reset values, no `res_valid`. A subsequent 1,1,1,1 frame → `res_data`=4.
- `in_valid` toggling 1/0 every cycle over two frames (3,-5,2,2 then 1,2,3,4) → results 4 then 10; no element lost or duplicated.

Source files
------------

// File: rtl/mcss_pkg.sv
// Shared types and helpers for the MCSS loader and the MCSS reduction tree.
package mcss_pkg;

    typedef enum logic [1:0] {FILL, WAIT, DONE} mcss_ld_state_t;

    // Pipeline depth of the MCSS tree for a given frame length.
    function automatic int unsigned mcss_latency(input int unsigned rows);
        return $clog2(rows);
    endfunction

endpackage

// File: rtl/mcss_stream_loader.sv
// Packs a serial valid/ready stream into a zero-padded MCSS frame, waits out
// the tree latency, then returns the captured MCSS value on a valid/ready port.
module mcss_stream_loader
    import mcss_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROWS       = 256
) (
    input  logic                                 clk,
    input  logic                                 rst_l,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_WIDTH-1:0]                in_data,
    input  logic                                 in_last,
    output logic [ROWS*DATA_WIDTH-1:0]           rows_out,
    input  logic [DATA_WIDTH-1:0]                mcss_in,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [DATA_WIDTH-1:0]                res_data,
    output logic [$clog2(ROWS):0]                frame_len
);

    localparam int unsigned LATENCY = mcss_latency(ROWS);
    localparam int unsigned IDX_W   = $clog2(ROWS);
    localparam int unsigned LEN_W   = IDX_W + 1;
    localparam int unsigned WCNT_W  = $clog2(LATENCY + 1);

    mcss_ld_state_t      state, state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [WCNT_W-1:0]   wcnt;
    logic                accept;
    logic                capture;
    logic                clear;

    // State register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes; a full frame closes regardless of in_last.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        clear     = 1'b0;
        case (state)
            FILL: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (in_last || (idx == IDX_W'(ROWS - 1))) begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wcnt == WCNT_W'(LATENCY)) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    clear     = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // Handshake flags track the state register exactly, one flop each.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == FILL);
            res_valid <= (state_nxt == DONE);
        end
    end

    // Frame buffer, counters and result capture.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rows_out  <= '0;
            idx       <= '0;
            frame_len <= '0;
            wcnt      <= '0;
            res_data  <= '0;
        end else begin
            if (accept) begin
                for (int unsigned k = 0; k < ROWS; k++) begin
                    if (idx == IDX_W'(k)) begin
                        rows_out[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                    end
                end
                idx       <= idx + IDX_W'(1);
                frame_len <= frame_len + LEN_W'(1);
            end
            if ((state == WAIT) && !capture) begin
                wcnt <= wcnt + WCNT_W'(1);
            end
            if (capture) begin
                res_data <= mcss_in;
            end
            if (clear) begin
                rows_out  <= '0;
                idx       <= '0;
                frame_len <= '0;
                wcnt      <= '0;
            end
        end
    end

endmodule
